// File: rtl/sha256_w_sequencer.sv
// SHA-256 message-word sequencer: loads one 16-word block, steps rounds 0..63,
// serves the schedule stage's four reads and forwards each scheduled word.
module sha256_w_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic [5:0]  round,
    input  logic [5:0]  addr_a,
    input  logic [5:0]  addr_b,
    input  logic [5:0]  addr_c,
    input  logic [5:0]  addr_d,
    output logic [31:0] rd_a,
    output logic [31:0] rd_b,
    output logic [31:0] rd_c,
    output logic [31:0] rd_d,
    input  logic [31:0] message,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_word,
    output logic [5:0]  w_round,
    output logic        block_done
);

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned ROUND_W     = 6;
    localparam int unsigned ROUNDS      = 64;
    localparam int unsigned BLOCK_WORDS = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ROUND_W-1:0]   cnt;
    logic [ROUND_W-1:0]   cnt_next;
    logic [WORD_W-1:0]    mem [ROUNDS];
    logic                 wr_en;
    logic [WORD_W-1:0]    wr_data;
    logic                 in_ready_next;
    logic                 w_valid_next;
    logic                 block_done_next;

    // Next-state, counter and write-port decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        wr_data    = in_word;
        unique case (state)
            LOAD: begin
                if (in_valid && in_ready) begin
                    wr_en = 1'b1;
                    if (cnt == ROUND_W'(BLOCK_WORDS - 1)) begin
                        cnt_next   = '0;
                        state_next = EXPAND;
                    end else begin
                        cnt_next = cnt + ROUND_W'(1);
                    end
                end
            end
            EXPAND: begin
                if (w_valid && w_ready) begin
                    wr_en   = (cnt >= ROUND_W'(BLOCK_WORDS));
                    wr_data = message;
                    if (cnt == ROUND_W'(ROUNDS - 1)) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt + ROUND_W'(1);
                    end
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = LOAD;
            end
            default: begin
                cnt_next   = '0;
                state_next = LOAD;
            end
        endcase
        in_ready_next   = (state_next == LOAD);
        w_valid_next    = (state_next == EXPAND);
        block_done_next = (state_next == DONE);
    end

    // Handshake flags are registered copies of the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            in_ready   <= 1'b1;
            w_valid    <= 1'b0;
            block_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            in_ready   <= in_ready_next;
            w_valid    <= w_valid_next;
            block_done <= block_done_next;
        end
    end

    // Word store is not reset; only written locations are ever read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt] <= wr_data;
        end
    end

    assign rd_a    = mem[addr_a];
    assign rd_b    = mem[addr_b];
    assign rd_c    = mem[addr_c];
    assign rd_d    = mem[addr_d];
    assign round   = cnt;
    assign w_round = cnt;
    assign w_word  = message;

endmodule

// File: tb/tb_sha256_w_sequencer.sv
// Scoreboard bench for sha256_w_sequencer with a behavioural schedule stage.
module tb_sha256_w_sequencer;

    typedef struct packed {
        logic [5:0]  rnd;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [5:0]  round;
    logic [5:0]  addr_a, addr_b, addr_c, addr_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;
    logic [31:0] message;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_round;
    logic        block_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int done_cyc = 0;
    int wv_rise_cyc = 0;
    int done_count = 0;
    bit rand_mode = 1'b0;
    exp_t exp_q[$];
    logic [31:0] abc_blk [16];

    sha256_w_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .round(round),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .addr_d(addr_d),
        .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c), .rd_d(rd_d),
        .message(message),
        .w_valid(w_valid), .w_ready(w_ready), .w_word(w_word), .w_round(w_round),
        .block_done(block_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Schedule stage: pass-through for rounds 0..15, recurrence afterwards
    always_comb begin
        addr_a  = round;
        addr_b  = round;
        addr_c  = round;
        addr_d  = round;
        message = rd_a;
        if (round >= 6'd16) begin
            addr_a  = round - 6'd2;
            addr_b  = round - 6'd7;
            addr_c  = round - 6'd15;
            addr_d  = round - 6'd16;
            message = ssig1(rd_a) + rd_b + ssig0(rd_c) + rd_d;
        end
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // sel=1: "abc" block with hand values for rounds 16/17; sel=0: all-zero block
    task automatic push_expected(input int sel);
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 64; t++) begin
            if (t < 16)                w[t] = (sel != 0) ? abc_blk[t] : 32'h0;
            else if (sel != 0 && t == 16) w[t] = 32'h61626380;
            else if (sel != 0 && t == 17) w[t] = 32'h000F0000;
            else w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
            e.rnd  = 6'(t);
            e.word = w[t];
            exp_q.push_back(e);
        end
    endtask

    // Called just after a posedge; returns just after the posedge of the last accept
    task automatic load_block(input int sel, input int nwords, input bit keep_valid);
        int n;
        for (int i = 0; i < nwords; i++) begin
            in_valid = 1'b1;
            in_word  = (sel != 0) ? abc_blk[i] : 32'h0;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                chk(1'b0, "load_timeout", 32'(in_ready), 32'h1);
                in_valid = 1'b0;
                return;
            end
            if (i == 0) hs_cyc = cyc;
            @(posedge clk);
            #1;
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(done_count >= target, "done_timeout", 32'(done_count), 32'(target));
        @(posedge clk);
        #1;
    endtask

    // Consumer readiness: held high or random per cycle
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each accepted word and checks protocol
    int          accepts = 0;
    logic [5:0]  last_round = '0;
    bit          stalled = 1'b0;
    bit          prev_done = 1'b0;
    bit          prev_wv = 1'b0;
    logic [31:0] held_word = '0;
    logic [5:0]  held_round = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            accepts   = 0;
            stalled   = 1'b0;
            prev_done = 1'b0;
            prev_wv   = 1'b0;
        end else begin
            if (stalled) begin
                chk(w_valid && w_word == held_word, "stall_word", w_word, held_word);
                chk(w_round == held_round, "stall_round", 32'(w_round), 32'(held_round));
            end
            stalled = 1'b0;
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_word", w_word, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk(w_round == e.rnd, "w_round", 32'(w_round), 32'(e.rnd));
                    chk(w_word == e.word, "w_word", w_word, e.word);
                end
                accepts++;
                last_round = w_round;
            end else if (w_valid) begin
                stalled    = 1'b1;
                held_word  = w_word;
                held_round = w_round;
            end
            if (w_valid && !prev_wv) wv_rise_cyc = cyc;
            if (in_valid && (w_valid || block_done))
                chk(!in_ready, "in_ready_busy", 32'(in_ready), 32'h0);
            if (prev_done)
                chk(!block_done, "done_one_cycle", 32'(block_done), 32'h0);
            if (block_done) begin
                chk(accepts == 64, "words_per_block", 32'(accepts), 32'd64);
                chk(last_round == 6'd63, "last_round", 32'(last_round), 32'd63);
                done_cyc = cyc;
                done_count++;
                accepts = 0;
            end
            prev_done = block_done;
            prev_wv   = w_valid;
        end
    end

    initial begin
        int target;
        for (int i = 0; i < 16; i++) abc_blk[i] = 32'h0;
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_word  = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'h1);
        chk(w_valid == 1'b0, "rst_w_valid", 32'(w_valid), 32'h0);
        chk(block_done == 1'b0, "rst_block_done", 32'(block_done), 32'h0);
        chk(round == 6'd0, "rst_round", 32'(round), 32'h0);
        chk(w_round == 6'd0, "rst_w_round", 32'(w_round), 32'h0);
        @(posedge clk);
        #1;

        // abc block, consumer always ready
        push_expected(1);
        load_block(1, 16, 1'b0);
        wait_done(1);

        // abc block, random backpressure
        rand_mode = 1'b1;
        push_expected(1);
        load_block(1, 16, 1'b0);
        wait_done(2);
        rand_mode = 1'b0;

        // stray input word while expanding
        push_expected(1);
        load_block(1, 16, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(3);

        // reset after a partial load
        load_block(1, 9, 1'b0);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "reset_mid_in_ready", 32'(in_ready), 32'h1);
        chk(w_valid == 1'b0, "reset_mid_w_valid", 32'(w_valid), 32'h0);
        chk(round == 6'd0, "reset_mid_round", 32'(round), 32'h0);
        @(posedge clk);
        #1;
        target = done_count + 1;
        push_expected(1);
        load_block(1, 16, 1'b0);
        wait_done(target);

        // back-to-back: zero block then abc with in_valid held high
        target = done_count + 2;
        push_expected(0);
        load_block(0, 16, 1'b1);
        push_expected(1);
        load_block(1, 16, 1'b0);
        chk(hs_cyc == done_cyc + 1, "b2b_load_start", 32'(hs_cyc), 32'(done_cyc + 1));
        wait_done(target);

        // throughput with everything held high
        target = done_count + 1;
        push_expected(1);
        load_block(1, 16, 1'b0);
        wait_done(target);
        chk(wv_rise_cyc - hs_cyc == 16, "first_w_latency", 32'(wv_rise_cyc - hs_cyc), 32'd16);
        chk(done_cyc - wv_rise_cyc == 64, "done_latency", 32'(done_cyc - wv_rise_cyc), 32'd64);

        repeat (4) @(posedge clk);
        chk(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
